pipe_skid_buf: RTL and testbench

- Two-entry registered pipeline stage with valid/ready handshake.
- Sits between two datapath stages wherever a plain flop register needs backpressure.
- Registers both the data and the ready path, so there is no combinational path from OutReady to InReady.
- Used ahead of the bus/IFU interface registers, where downstream stalls must not ripple combinationally upstream.

---
 rtl/pipe_skid_buf.sv | 130 +++++++++++++
 tb/tb_pipe_skid_buf.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: two-entry registered pipeline stage with a valid/ready
// handshake. Both the data and the ready path are registered, so InReady
// depends only on local state and there is no combinational path from
// OutReady to InReady.
// Optional stall statistics counter: define PIPE_SKID_BUF_STALLCNT_EN.
module pipe_skid_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             FlushI,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InData,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutData,
    output logic [1:0]       Occupancy,
    output logic [31:0]      StallCount
);

    // The state encoding is exactly {main valid, skid valid}; (0,1) is never reached.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        TWO   = 2'b11
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] main_data_reg, skid_data_reg;
    logic             main_valid, skid_valid;
    logic             acc, deq;
    logic             load_main_in, load_main_skid, load_skid;

    assign main_valid = state_reg[1];
    assign skid_valid = state_reg[0];

    assign InReady   = ~skid_valid;
    assign OutValid  = main_valid;
    assign OutData   = main_data_reg;
    assign Occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    assign acc = InValid & InReady;
    assign deq = OutValid & OutReady;

    // State register; reset takes effect immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and data-register load enables; flush wins over any handshake.
    always_comb begin
        state_next     = state_reg;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (FlushI) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (acc) begin
                        state_next   = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (acc && deq) begin
                        load_main_in = 1'b1;
                    end else if (acc) begin
                        state_next = TWO;
                        load_skid  = 1'b1;
                    end else if (deq) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    // InReady is low here, so only a dequeue can happen.
                    if (deq) begin
                        state_next     = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    // Data registers load only on their own load condition, never on idle cycles,
    // so garbage on InData while InValid is low cannot reach OutData.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_data_reg <= '0;
            skid_data_reg <= '0;
        end else begin
            if (load_main_in) begin
                main_data_reg <= InData;
            end else if (load_main_skid) begin
                main_data_reg <= skid_data_reg;
            end
            if (load_skid) begin
                skid_data_reg <= InData;
            end
        end
    end

`ifdef PIPE_SKID_BUF_STALLCNT_EN
    logic [31:0] stall_cnt_reg;

    // Saturating count of edges where a valid beat is held back; flush does not clear it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_reg <= 32'h0;
        end else if (main_valid && !OutReady && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign StallCount = stall_cnt_reg;
`else
    assign StallCount = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Self-checking bench for pipe_skid_buf: a vector table, hand-written corner
// sequences and a randomized run, all compared against a queue-based model.
module tb_pipe_skid_buf;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
`ifdef PIPE_SKID_BUF_STALLCNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        FlushI;
    logic        InValid;
    logic        InReady;
    logic [31:0] InData;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutData;
    logic [1:0]  Occupancy;
    logic [31:0] StallCount;

    pipe_skid_buf #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .FlushI    (FlushI),
        .InValid   (InValid),
        .InReady   (InReady),
        .InData    (InData),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .OutData   (OutData),
        .Occupancy (Occupancy),
        .StallCount(StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic [31:0] ed;
        logic [1:0]  eo;
        logic        eir;
    } vec_t;

    vec_t        tbl[16];
    logic [31:0] q[$];
    logic [31:0] model_stall;
    int          n_tests;
    int          n_fail;
    int          cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare every DUT output against the queue model.
    task automatic check_model();
        chk("out_valid", 32'(OutValid), 32'(q.size() > 0));
        chk("occupancy", 32'(Occupancy), 32'(q.size()));
        chk("in_ready", 32'(InReady), 32'(q.size() < 2));
        if (q.size() > 0) chk("out_data", OutData, q[0]);
        chk("stall_count", StallCount, model_stall);
    endtask

    // One clock: drive inputs after the falling edge, update the model at the
    // rising edge, then check outputs 1 time unit later.
    task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        bit acc, deq;
        @(negedge clk);
        InValid  = iv;
        InData   = d;
        OutReady = ordy;
        FlushI   = fl;
        acc = iv && (q.size() < 2);
        deq = (q.size() > 0) && ordy;
        @(posedge clk);
        if (STALL_EN && q.size() > 0 && !ordy && model_stall != 32'hFFFF_FFFF) model_stall++;
        if (fl) begin
            q.delete();
        end else begin
            if (deq) void'(q.pop_front());
            if (acc) q.push_back(d);
        end
        #1;
        cyc++;
        $display("[TB] cyc %0d in v=%b d=%h ordy=%b fl=%b -> out v=%b d=%h occ=%0d ir=%b sc=%0d",
                 cyc, iv, d, ordy, fl, OutValid, OutData, Occupancy, InReady, StallCount);
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        q.delete();
        model_stall = 32'h0;
        chk("reset_out_valid", 32'(OutValid), 32'h0);
        chk("reset_in_ready", 32'(InReady), 32'h1);
        chk("reset_occupancy", 32'(Occupancy), 32'h0);
        chk("reset_out_data", OutData, 32'h0);
        chk("reset_stall", StallCount, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        cyc         = 0;
        model_stall = 32'h0;
        reset    = 1'b1;
        FlushI   = 1'b0;
        InValid  = 1'b0;
        InData   = 32'h0;
        OutReady = 1'b0;

        //            iv  data           ordy fl  ev  edata        eo     eir
        tbl[0]  = '{H, 32'h1,        H, L, H, 32'h1,    2'd1, H};
        tbl[1]  = '{H, 32'h2,        H, L, H, 32'h2,    2'd1, H};
        tbl[2]  = '{H, 32'h3,        H, L, H, 32'h3,    2'd1, H};
        tbl[3]  = '{H, 32'h4,        H, L, H, 32'h4,    2'd1, H};
        tbl[4]  = '{L, 32'h0,        H, L, L, 32'h0,    2'd0, H};
        tbl[5]  = '{H, 32'h10,       L, L, H, 32'h10,   2'd1, H};
        tbl[6]  = '{H, 32'h20,       L, L, H, 32'h10,   2'd2, L};
        tbl[7]  = '{H, 32'h99,       L, L, H, 32'h10,   2'd2, L};
        tbl[8]  = '{L, 32'h0,        H, L, H, 32'h20,   2'd1, H};
        tbl[9]  = '{L, 32'h0,        H, L, L, 32'h0,    2'd0, H};
        tbl[10] = '{H, 32'h5,        L, L, H, 32'h5,    2'd1, H};
        tbl[11] = '{H, 32'h6,        H, L, H, 32'h6,    2'd1, H};
        tbl[12] = '{L, 32'hDEAD_BEEF, L, L, H, 32'h6,   2'd1, H};
        tbl[13] = '{H, 32'h7,        H, L, H, 32'h7,    2'd1, H};
        tbl[14] = '{H, 32'h8,        L, H, L, 32'h0,    2'd0, H};
        tbl[15] = '{L, 32'h0,        H, L, L, 32'h0,    2'd0, H};

        #1;
        chk("por_out_valid", 32'(OutValid), 32'h0);
        chk("por_in_ready", 32'(InReady), 32'h1);
        do_reset();

        // Vector table: streaming, skid backpressure, accept+dequeue, flush priority.
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
            chk($sformatf("tbl%0d_valid", i), 32'(OutValid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_occ", i), 32'(Occupancy), 32'(tbl[i].eo));
            chk($sformatf("tbl%0d_ready", i), 32'(InReady), 32'(tbl[i].eir));
            if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), OutData, tbl[i].ed);
        end

        // Asynchronous reset mid-stream while holding two beats.
        cycle(H, 32'hAAAA_0001, L, L);
        cycle(H, 32'hAAAA_0002, L, L);
        chk("two_occ", 32'(Occupancy), 32'd2);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        model_stall = 32'h0;
        chk("async_rst_valid", 32'(OutValid), 32'h0);
        chk("async_rst_ready", 32'(InReady), 32'h1);
        chk("async_rst_occ", 32'(Occupancy), 32'h0);
        chk("async_rst_data", OutData, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cycle(L, 32'h0, H, L);

        // Stall counting: one held beat, five stalled edges.
        cycle(H, 32'h33, L, L);
        for (int i = 0; i < 5; i++) cycle(L, 32'h0, L, L);
        chk("stall_5", StallCount, STALL_EN ? 32'd5 : 32'd0);
`ifdef PIPE_SKID_BUF_STALLCNT_EN
        @(negedge clk);
        dut.stall_cnt_reg = 32'hFFFF_FFFE;
        model_stall = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) cycle(L, 32'h0, L, L);
        chk("stall_sat", StallCount, 32'hFFFF_FFFF);
        cycle(L, 32'h0, L, H);
        chk("stall_after_flush", StallCount, 32'hFFFF_FFFF);
`endif
        do_reset();

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
